// File: rtl/crc_misr_sig.sv
// crc_misr_sig: multi-channel CRC/MISR signature compactor.
// Compress, scan, seed and hold modes, plus a windowed snapshot FSM.
module crc_misr_sig #(
  parameter int WIDTH    = 32,
  parameter int POLY     = 32'h0001_0811,
  parameter int CHANNELS = 2,
  parameter int CNT_W    = 8,
  localparam int SEL_W   = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                      CLK,
  input  logic                      RESET,
  input  logic                      TM1,
  input  logic                      TM0,
  input  logic                      din_valid,
  input  logic [CHANNELS*WIDTH-1:0] din,
  input  logic                      start,
  input  logic [CNT_W-1:0]          win_len,
  input  logic [SEL_W-1:0]          rd_sel,
  input  logic                      scan_in,
  output logic                      scan_out,
  output logic                      busy,
  output logic                      done,
  output logic                      abort,
  output logic [WIDTH-1:0]          sig_out,
  output logic [WIDTH-1:0]          snap_out
);

  localparam int N = WIDTH * CHANNELS;
  localparam logic [WIDTH-1:0] TAPS = WIDTH'(POLY);

  localparam logic [1:0] M_HOLD = 2'b00;
  localparam logic [1:0] M_COMP = 2'b01;
  localparam logic [1:0] M_SCAN = 2'b10;
  localparam logic [1:0] M_SEED = 2'b11;

  typedef enum logic {S_IDLE, S_RUN} state_t;

  state_t state_q, state_d;
  logic [CHANNELS-1:0][WIDTH-1:0] sig_q, sig_d;
  logic [CHANNELS-1:0][WIDTH-1:0] snap_q, snap_d;
  logic [CHANNELS-1:0][WIDTH-1:0] din_w;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic done_q, done_d;
  logic abort_q, abort_d;
  logic so_q, so_d;
  logic [1:0] mode;

  assign mode  = {TM1, TM0};
  assign din_w = din;

  function automatic logic [WIDTH-1:0] step(
    input logic [WIDTH-1:0] s,
    input logic [WIDTH-1:0] d
  );
    return {s[WIDTH-2:0], 1'b0}
         ^ (s[WIDTH-1] ? TAPS : '0)
         ^ d;
  endfunction

  // Signature datapath: next value of every channel per test mode.
  always_comb begin
    sig_d = sig_q;
    so_d  = so_q;
    unique case (mode)
      M_COMP: begin
        if (din_valid) begin
          for (int c = 0; c < CHANNELS; c++) begin
            sig_d[c] = step(sig_q[c], din_w[c]);
          end
        end
      end
      M_SCAN: begin
        sig_d = N'({sig_q, scan_in});
        so_d  = sig_q[CHANNELS-1][WIDTH-1];
      end
      M_SEED: begin
        if (din_valid) sig_d = din_w;
      end
      default: begin
        sig_d = sig_q;
      end
    endcase
  end

  // Window FSM: counts compress beats, snapshots on completion.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    snap_d  = snap_q;
    done_d  = 1'b0;
    abort_d = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          if (win_len != '0) begin
            state_d = S_RUN;
            cnt_d   = win_len;
          end else begin
            snap_d = sig_q;
            done_d = 1'b1;
          end
        end
      end
      S_RUN: begin
        if (mode != M_COMP) begin
          state_d = S_IDLE;
          abort_d = 1'b1;
        end else if (din_valid && cnt_q != '0) begin
          cnt_d = cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) begin
            snap_d  = sig_d;
            done_d  = 1'b1;
            state_d = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State registers with synchronous reset.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q <= S_IDLE;
      sig_q   <= '0;
      snap_q  <= '0;
      cnt_q   <= '0;
      done_q  <= 1'b0;
      abort_q <= 1'b0;
      so_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      sig_q   <= sig_d;
      snap_q  <= snap_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
      abort_q <= abort_d;
      so_q    <= so_d;
    end
  end

  // Read muxes; out-of-range selects read zero.
  always_comb begin
    sig_out  = '0;
    snap_out = '0;
    if (int'(rd_sel) < CHANNELS) begin
      sig_out  = sig_q[rd_sel];
      snap_out = snap_q[rd_sel];
    end
  end

  assign busy     = (state_q == S_RUN);
  assign done     = done_q;
  assign abort    = abort_q;
  assign scan_out = so_q;

endmodule

// File: tb/tb_crc_misr_sig.sv
// tb_crc_misr_sig: directed plus random checks of crc_misr_sig
// against a behavioural signature/window model.
module tb_crc_misr_sig;

  localparam logic [31:0] POLY = 32'h0001_0811;

  logic        CLK = 1'b0;
  logic        RESET;
  logic        TM1, TM0;
  logic        din_valid;
  logic [63:0] din;
  logic        start;
  logic [7:0]  win_len;
  logic        rd_sel;
  logic        scan_in;
  logic        scan_out, busy, done, abort;
  logic [31:0] sig_out, snap_out;

  crc_misr_sig dut (
    .CLK(CLK), .RESET(RESET), .TM1(TM1), .TM0(TM0),
    .din_valid(din_valid), .din(din), .start(start),
    .win_len(win_len), .rd_sel(rd_sel), .scan_in(scan_in),
    .scan_out(scan_out), .busy(busy), .done(done),
    .abort(abort), .sig_out(sig_out), .snap_out(snap_out)
  );

  always #5 CLK = ~CLK;

  int nvec = 0;
  int nerr = 0;

  bit [31:0] ms [2];
  bit [31:0] mn [2];
  bit        mrun  = 0;
  int        mcnt  = 0;
  bit        mdone = 0;
  bit        mabort = 0;
  bit        mso   = 0;

  function automatic bit [31:0] mstep(bit [31:0] s, bit [31:0] d);
    return (s << 1) ^ (s[31] ? POLY : 32'h0) ^ d;
  endfunction

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    for (int c = 0; c < 2; c++) begin
      rd_sel = c[0];
      #1;
      chk("sig", sig_out, ms[c]);
      chk("snap", snap_out, mn[c]);
    end
    chk("busy", {31'b0, busy}, {31'b0, mrun});
    chk("done", {31'b0, done}, {31'b0, mdone});
    chk("abort", {31'b0, abort}, {31'b0, mabort});
    chk("scan_out", {31'b0, scan_out}, {31'b0, mso});
  endtask

  task automatic peek(string tag, bit sel, bit snap,
                      logic [31:0] exp);
    rd_sel = sel;
    #1;
    chk(tag, snap ? snap_out : sig_out, exp);
  endtask

  task automatic step(bit [1:0] md, bit v, bit [63:0] d,
                      bit st, bit [7:0] wl, bit si, bit rst);
    bit [31:0] ns [2];
    bit [31:0] nsn [2];
    bit [63:0] ch;
    bit nrun, ndone, nabort, nso;
    int ncnt;
    {TM1, TM0} = md;
    din_valid = v;
    din = d;
    start = st;
    win_len = wl;
    scan_in = si;
    RESET = rst;
    ns = ms;
    nsn = mn;
    nrun = mrun;
    ncnt = mcnt;
    ndone = 0;
    nabort = 0;
    nso = mso;
    case (md)
      2'd1: if (v) begin
        for (int c = 0; c < 2; c++)
          ns[c] = mstep(ms[c], d[c*32 +: 32]);
      end
      2'd2: begin
        ch = {ms[1], ms[0]};
        nso = ch[63];
        ch = {ch[62:0], si};
        ns[0] = ch[31:0];
        ns[1] = ch[63:32];
      end
      2'd3: if (v) begin
        ns[0] = d[31:0];
        ns[1] = d[63:32];
      end
      default: ;
    endcase
    if (!mrun) begin
      if (st) begin
        if (wl != 0) begin
          nrun = 1;
          ncnt = wl;
        end else begin
          nsn = ms;
          ndone = 1;
        end
      end
    end else if (md != 2'd1) begin
      nrun = 0;
      nabort = 1;
    end else if (v) begin
      ncnt--;
      if (ncnt == 0) begin
        nsn = ns;
        ndone = 1;
        nrun = 0;
      end
    end
    if (rst) begin
      ns = '{0, 0};
      nsn = '{0, 0};
      nrun = 0; ncnt = 0; ndone = 0; nabort = 0; nso = 0;
    end
    @(posedge CLK);
    #1;
    ms = ns; mn = nsn; mrun = nrun; mcnt = ncnt;
    mdone = ndone; mabort = nabort; mso = nso;
    check_all();
  endtask

  initial begin
    bit [1:0] md;
    int r;
    ms = '{0, 0};
    mn = '{0, 0};
    RESET = 1; TM1 = 0; TM0 = 0; din_valid = 0; din = '0;
    start = 0; win_len = '0; rd_sel = 0; scan_in = 0;

    step(2'd0, 0, 64'h0, 0, 8'd0, 0, 1);
    step(2'd0, 0, 64'h0, 0, 8'd0, 0, 1);
    step(2'd0, 0, 64'h0, 0, 8'd0, 0, 0);

    step(2'd1, 1, 64'h1, 0, 8'd0, 0, 0);
    peek("t1_sig0", 0, 0, 32'h1);
    peek("t1_sig1", 1, 0, 32'h0);
    peek("t1_snap0", 0, 1, 32'h0);

    step(2'd3, 1, 64'h0000_0000_8000_0000, 0, 8'd0, 0, 0);
    step(2'd1, 1, 64'h0, 0, 8'd0, 0, 0);
    peek("t2_sig0a", 0, 0, 32'h0001_0811);
    step(2'd1, 1, 64'h0, 0, 8'd0, 0, 0);
    peek("t2_sig0b", 0, 0, 32'h0002_1022);

    step(2'd3, 1, 64'h0, 0, 8'd0, 0, 0);
    step(2'd1, 0, 64'h0, 1, 8'd3, 0, 0);
    step(2'd1, 1, 64'h1, 0, 8'd0, 0, 0);
    step(2'd1, 0, 64'h0, 0, 8'd0, 0, 0);
    step(2'd1, 1, 64'h1, 0, 8'd0, 0, 0);
    step(2'd1, 0, 64'h0, 0, 8'd0, 0, 0);
    step(2'd1, 1, 64'h1, 0, 8'd0, 0, 0);
    chk("t3_done", {31'b0, done}, 32'h1);
    peek("t3_snap0", 0, 1, 32'h7);
    peek("t3_sig0", 0, 0, 32'h7);
    step(2'd1, 0, 64'h0, 0, 8'd0, 0, 0);

    step(2'd3, 1, 64'h8000_0000_0000_0000, 0, 8'd0, 0, 0);
    for (int i = 0; i < 64; i++) begin
      step(2'd2, 0, 64'h0, 0, 8'd0, 1, 0);
      if (i == 0) chk("t4_first", {31'b0, scan_out}, 32'h1);
    end
    peek("t4_sig0", 0, 0, 32'hFFFF_FFFF);
    peek("t4_sig1", 1, 0, 32'hFFFF_FFFF);

    step(2'd3, 1, 64'h0, 0, 8'd0, 0, 0);
    step(2'd1, 0, 64'h0, 1, 8'd5, 0, 0);
    step(2'd1, 1, {$urandom, $urandom}, 0, 8'd0, 0, 0);
    step(2'd1, 1, {$urandom, $urandom}, 0, 8'd0, 0, 0);
    step(2'd0, 1, {$urandom, $urandom}, 0, 8'd0, 0, 0);
    chk("t5_abort", {31'b0, abort}, 32'h1);
    step(2'd0, 0, 64'h0, 0, 8'd0, 0, 0);

    step(2'd1, 0, 64'h0, 1, 8'd4, 0, 0);
    step(2'd1, 1, {$urandom, $urandom}, 0, 8'd0, 0, 0);
    step(2'd1, 1, 64'h0, 0, 8'd0, 0, 1);
    chk("t6_busy", {31'b0, busy}, 32'h0);
    step(2'd1, 0, 64'h0, 1, 8'd0, 0, 0);
    chk("t6_done", {31'b0, done}, 32'h1);
    peek("t6_snap0", 0, 1, 32'h0);

    for (int i = 0; i < 400; i++) begin
      r = $urandom_range(0, 9);
      md = (r == 6) ? 2'd0 : (r == 7) ? 2'd2 :
           (r == 8) ? 2'd3 : 2'd1;
      step(md, ($urandom % 4) != 0, {$urandom, $urandom},
           ($urandom % 8) == 0, 8'($urandom_range(0, 6)),
           1'($urandom), ($urandom % 97) == 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/crc_misr_sig.md
Name: crc_misr_sig

Overview:
- Parametrised multi-channel CRC/MISR signature compactor for built-in test of wide datapath buses.
- Generalises the fixed 32-bit single-channel signature chain to configurable width, polynomial and channel count.
- Adds a windowed compression FSM with a snapshot register, a serial scan chain and seed load.
- Mode is selected by the TM1/TM0 test-mode pins.

Parameters:
WIDTH, 32, signature/data word width per channel (>=4)
POLY, 32'h0001_0811, Galois feedback taps, low WIDTH bits used; bit0 must be 1
CHANNELS, 2, independent signature registers sharing control (>=1)
CNT_W, 8, width of window length counter

Ports:
CLK  in  1  clock, all state updates on rising edge
RESET  in  1  synchronous, active-high reset
TM1  in  1  mode select MSB
TM0  in  1  mode select LSB
din_valid  in  1  data beat qualifier
din  in  CHANNELS*WIDTH  channel c occupies bits [c*WIDTH +: WIDTH]
start  in  1  begin compression window (pulse)
win_len  in  CNT_W  number of beats in window, sampled on accepted start
rd_sel  in  max(1,clog2(CHANNELS))  channel selected for sig_out/snap_out
scan_in  in  1  serial scan input
scan_out  out  1  serial scan output
busy  out  1  window in progress
done  out  1  one-cycle pulse, window complete
abort  out  1  one-cycle pulse, window cancelled
sig_out  out  WIDTH  live signature of channel rd_sel
snap_out  out  WIDTH  snapshot of channel rd_sel

Behaviour:
- Reset: all signatures, snapshots and the counter are 0. FSM goes to IDLE. busy, done, abort and scan_out are 0. RESET has priority over every other input.
- Step function per channel: fb = sig[WIDTH-1]; next = ({sig[WIDTH-2:0],1'b0} ^ (fb ? POLY : 0)) ^ din_c.
- Mode {TM1,TM0}:
  - 00 HOLD: signatures unchanged.
  - 01 COMPRESS: on din_valid, every channel takes its step; no change without din_valid.
  - 10 SCAN: every cycle all channels form one chain. Bit order is ch0 bit0 .. ch0 MSB, then ch1 bit0, and so on. scan_in enters ch0 bit0; each channel's MSB feeds the next channel's bit0. scan_out is the registered MSB of channel CHANNELS-1 (value before the shift).
  - 11 SEED: on din_valid, sig_c <= din_c.
- FSM states:
  - IDLE, start=1 and win_len!=0: go to RUN, cnt <= win_len, busy=1.
  - IDLE, start=1 and win_len==0: snapshot all channels <= current sig; done pulses next cycle; stay IDLE.
  - RUN: each COMPRESS-mode beat with din_valid decrements cnt. On the beat where cnt==1, snapshot <= the post-step signature, done=1 for the following cycle, FSM -> IDLE, busy=0 in that same cycle.
  - RUN, mode != 01: beats are not counted. FSM -> IDLE, abort=1 for one cycle, snapshot unchanged. Signatures still follow the new mode.
  - start while busy is ignored.
- sig_out and snap_out are combinational muxes on rd_sel. rd_sel >= CHANNELS reads 0.
- RESET mid-window: no done, no abort. Next cycle is IDLE with all state 0.
- Counter never wraps: it only decrements in RUN with cnt>=1.
- Registered latency:
  - A signature step is visible on sig_out the cycle after the accepting edge.
  - done/abort follow the terminating edge by one cycle.

Test Plan:
1. WIDTH=32, CHANNELS=2, reset; mode 01; one beat with ch0=0x00000001, ch1=0 -> sig0=0x00000001, sig1=0, snap_out=0, busy=0.
2. Mode 11 seed ch0=0x80000000; then mode 01 beat with din=0 -> sig0=0x00010811. A second zero beat -> sig0=0x00021022.
3. Seed 0; mode 01; start with win_len=3; three valid beats of 0x00000001 with idle gaps between them -> busy high throughout. done is a single pulse the cycle after the third beat. snap0 equals the live sig0 at that point (0x00000007).
4. Mode 10; seed ch1=0x80000000 beforehand; shift 64 cycles with scan_in=1 -> scan_out is first 1 (cycle 1), then the ch1 contents in MSB-first order. Both channels end at 0xFFFFFFFF.
5. Window with win_len=5; after 2 beats switch to mode 00 -> abort pulse, busy=0, snapshot unchanged, signatures held.
6. Window running with win_len=4; assert RESET after 1 beat -> no done/abort. All signatures and snapshots 0, FSM IDLE. A start with win_len=0 then gives done next cycle and snapshot=0.
